dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the memory-side bus of dmem_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the memory.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          req0;
  logic          we0;
  logic          lock0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic          lock1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, we0, lock0, addr0, wdata0,
    output gnt0, rvalid0, rdata0,
    input  req1, we1, lock1, addr1, wdata1,
    output gnt1, rvalid1, rdata1,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0, we0, lock0, addr0, wdata0,
    input  gnt0, rvalid0, rdata0,
    output req1, we1, lock1, addr1, wdata1,
    input  gnt1, rvalid1, rdata1,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous data memory,
// with a bounded lock so one owner can run read-modify-write sequences.
module dmem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int MAXLOCK = 4
) (
  input  logic           clock,
  input  logic           resetn,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] MAXCNT = 4'(MAXLOCK);

  state_t        state_r;
  state_t        state_nxt_s;
  logic          last_r;
  logic          last_nxt_s;
  logic [3:0]    cnt_r;
  logic [3:0]    cnt_nxt_s;
  logic          gnt0_s;
  logic          gnt1_s;
  logic          own_hit_s;
  logic          pend0_r;
  logic          pend1_r;
  logic [DW-1:0] hold0_r;
  logic [DW-1:0] hold1_r;
  logic [AW-1:0] addr_hold_r;
  logic [AW-1:0] mem_addr_s;

  // Grant decision and next arbitration state; grants are forced low while reset is held.
  always_comb begin
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    own_hit_s   = 1'b0;
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    cnt_nxt_s   = cnt_r;
    if (resetn) begin
      // An owner keeps the memory only while it requests and has budget left.
      case (state_r)
        OWN0: begin
          if (bus.req0 && (cnt_r < MAXCNT)) begin
            gnt0_s    = 1'b1;
            own_hit_s = 1'b1;
          end else begin
            own_hit_s = 1'b0;
          end
        end
        OWN1: begin
          if (bus.req1 && (cnt_r < MAXCNT)) begin
            gnt1_s    = 1'b1;
            own_hit_s = 1'b1;
          end else begin
            own_hit_s = 1'b0;
          end
        end
        default: own_hit_s = 1'b0;
      endcase

      if (!own_hit_s) begin
        if (bus.req0 && bus.req1) begin
          gnt0_s = last_r;
          gnt1_s = ~last_r;
        end else begin
          gnt0_s = bus.req0;
          gnt1_s = bus.req1 & ~bus.req0;
        end
      end else begin
        gnt0_s = gnt0_s;
      end

      if (own_hit_s) begin
        cnt_nxt_s = cnt_r + 4'd1;
        if ((gnt0_s && bus.lock0) || (gnt1_s && bus.lock1)) begin
          state_nxt_s = state_r;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end
      end else if (gnt0_s) begin
        last_nxt_s  = 1'b0;
        state_nxt_s = bus.lock0 ? OWN0 : IDLE;
        cnt_nxt_s   = bus.lock0 ? 4'd1 : 4'd0;
      end else if (gnt1_s) begin
        last_nxt_s  = 1'b1;
        state_nxt_s = bus.lock1 ? OWN1 : IDLE;
        cnt_nxt_s   = bus.lock1 ? 4'd1 : 4'd0;
      end else begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // Memory bus mux; the address holds its last granted value when idle.
  always_comb begin
    mem_addr_s = addr_hold_r;
    if (gnt0_s) begin
      mem_addr_s = bus.addr0;
    end else if (gnt1_s) begin
      mem_addr_s = bus.addr1;
    end else begin
      mem_addr_s = addr_hold_r;
    end
  end

  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_we    = (gnt0_s & bus.we0) | (gnt1_s & bus.we1);
  assign bus.mem_wdata = gnt0_s ? bus.wdata0 : (gnt1_s ? bus.wdata1 : {DW{1'b0}});
  assign bus.gnt0      = gnt0_s;
  assign bus.gnt1      = gnt1_s;

  // Arbitration state, address hold and read-return tracking.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      last_r      <= 1'b1;
      cnt_r       <= 4'd0;
      pend0_r     <= 1'b0;
      pend1_r     <= 1'b0;
      hold0_r     <= {DW{1'b0}};
      hold1_r     <= {DW{1'b0}};
      addr_hold_r <= {AW{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      last_r      <= last_nxt_s;
      cnt_r       <= cnt_nxt_s;
      pend0_r     <= gnt0_s & ~bus.we0;
      pend1_r     <= gnt1_s & ~bus.we1;
      hold0_r     <= pend0_r ? bus.mem_rdata : hold0_r;
      hold1_r     <= pend1_r ? bus.mem_rdata : hold1_r;
      addr_hold_r <= mem_addr_s;
    end
  end

  // Memory data arrives the cycle after the address, so it is passed through on the valid
  // cycle and captured for the hold that follows.
  assign bus.rvalid0 = pend0_r;
  assign bus.rvalid1 = pend1_r;
  assign bus.rdata0  = pend0_r ? bus.mem_rdata : hold0_r;
  assign bus.rdata1  = pend1_r ? bus.mem_rdata : hold1_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a synchronous memory model and a
// read-data scoreboard; reset corner cases are hand-written sequences.
module tb_dmem_arbiter;

  logic clock;
  logic resetn;

  dmem_arbiter_if #(.AW(8), .DW(32)) bus ();

  dmem_arbiter #(.AW(8), .DW(32), .MAXLOCK(4)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       r0;
    logic       w0;
    logic       l0;
    logic [7:0] a0;
    logic [31:0] d0;
    logic       r1;
    logic       w1;
    logic       l1;
    logic [7:0] a1;
    logic [31:0] d1;
    logic       g0;
    logic       g1;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [31:0] mem_model [256];
  logic [31:0] ref_mem [256];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [7:0]  exp_addr;
  vec_t        tbl [$];

  function automatic logic [31:0] init_val(input int i);
    return (i == 16) ? 32'hDEADBEEF : (32'hA55A0000 | 32'(i));
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] <= init_val(i);
  end

  always @(posedge clock) begin
    if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem_model[bus.mem_addr];
  end

  function automatic vec_t mk(input logic r0, input logic w0, input logic l0,
                              input logic [7:0] a0, input logic [31:0] d0,
                              input logic r1, input logic w1, input logic l1,
                              input logic [7:0] a1, input logic [31:0] d1,
                              input logic g0, input logic g1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.req0 = v.r0; bus.we0 = v.w0; bus.lock0 = v.l0; bus.addr0 = v.a0; bus.wdata0 = v.d0;
    bus.req1 = v.r1; bus.we1 = v.w1; bus.lock1 = v.l1; bus.addr1 = v.a1; bus.wdata1 = v.d1;
  endtask

  task automatic check_rvalid();
    logic [31:0] e;
    chk("rvalid0", {31'd0, bus.rvalid0}, {31'd0, (q0.size() > 0)});
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("rdata0", bus.rdata0, e);
    end
    chk("rvalid1", {31'd0, bus.rvalid1}, {31'd0, (q1.size() > 0)});
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("rdata1", bus.rdata1, e);
    end
  endtask

  // One cycle: drive at negedge, check the returned read of the previous cycle and this
  // cycle's grant/bus, then record the expected effect in the reference memory.
  task automatic apply(input vec_t v, input int idx);
    logic       ew;
    logic [31:0] ed;
    @(negedge clock);
    drive(v);
    #1;
    check_rvalid();
    chk($sformatf("gnt0[%0d]", idx), {31'd0, bus.gnt0}, {31'd0, v.g0});
    chk($sformatf("gnt1[%0d]", idx), {31'd0, bus.gnt1}, {31'd0, v.g1});
    if (v.g0) exp_addr = v.a0;
    else if (v.g1) exp_addr = v.a1;
    else exp_addr = exp_addr;
    ew = (v.g0 & v.w0) | (v.g1 & v.w1);
    ed = v.g0 ? v.d0 : v.d1;
    chk($sformatf("mem_we[%0d]", idx), {31'd0, bus.mem_we}, {31'd0, ew});
    chk($sformatf("mem_addr[%0d]", idx), {24'd0, bus.mem_addr}, {24'd0, exp_addr});
    if (ew) begin
      chk($sformatf("mem_wdata[%0d]", idx), bus.mem_wdata, ed);
      ref_mem[exp_addr] = ed;
    end
    if (v.g0 && !v.w0) q0.push_back(ref_mem[v.a0]);
    if (v.g1 && !v.w1) q1.push_back(ref_mem[v.a1]);
  endtask

  vec_t idle_v;
  vec_t both_v;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    exp_addr = 8'd0;
    idle_v = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0);
    drive(idle_v);
    resetn = 1'b0;

    // Reset values
    repeat (3) @(negedge clock);
    #1;
    chk("rst_gnt0", {31'd0, bus.gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, bus.gnt1}, 32'd0);
    chk("rst_rvalid0", {31'd0, bus.rvalid0}, 32'd0);
    chk("rst_rvalid1", {31'd0, bus.rvalid1}, 32'd0);
    chk("rst_rdata0", bus.rdata0, 32'd0);
    chk("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    resetn = 1'b1;

    // Read, write, read-back, alternation, lock limits, lock release, port-1 traffic
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h10, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b1, 1'b0));
    tbl.push_back(idle_v);
    tbl.push_back(idle_v);
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 8'h05, 32'h12345678, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b1, 1'b0));
    tbl.push_back(idle_v);
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h05, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h01, 32'd0, 1'b1, 1'b0, 1'b0, 8'h02, 32'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h01, 32'd0, 1'b1, 1'b0, 1'b0, 8'h02, 32'd0, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h03, 32'd0, 1'b1, 1'b0, 1'b1, 8'h04, 32'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h03, 32'd0, 1'b1, 1'b0, 1'b1, 8'h04, 32'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h03, 32'd0, 1'b1, 1'b0, 1'b1, 8'h04, 32'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h03, 32'd0, 1'b0, 1'b0, 1'b0, 8'h04, 32'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 8'h08, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h08, 32'd0, 1'b1, 1'b0, 1'b0, 8'h09, 32'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h0B, 32'd0, 1'b1, 1'b0, 1'b0, 8'h0C, 32'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h0B, 32'd0, 1'b1, 1'b0, 1'b0, 8'h0C, 32'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b1, 1'b1, 1'b0, 8'h07, 32'hCAFEF00D, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 1'b0, 8'h07, 32'd0, 1'b0, 1'b1));
    tbl.push_back(idle_v);
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 1'b1, 8'h0A, 32'd0, 1'b0, 1'b1));
    tbl.push_back(idle_v);
    tbl.push_back(idle_v);

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset between a granted read and its return edge
    apply(mk(1'b1, 1'b0, 1'b0, 8'h10, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b1, 1'b0), 100);
    resetn = 1'b0;
    q0.delete();
    q1.delete();
    exp_addr = 8'd0;
    #1;
    chk("midrst_gnt0", {31'd0, bus.gnt0}, 32'd0);
    chk("midrst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("midrst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    @(negedge clock);
    #1;
    chk("midrst_rvalid0", {31'd0, bus.rvalid0}, 32'd0);
    chk("midrst_rdata0", bus.rdata0, 32'd0);
    drive(idle_v);
    resetn = 1'b1;

    // Continuous tie from reset alternates starting with port 0
    for (int i = 0; i < 4; i++) begin
      both_v = mk(1'b1, 1'b0, 1'b0, 8'h20, 32'd0, 1'b1, 1'b0, 1'b0, 8'h21, 32'd0,
                  (i % 2 == 0), (i % 2 == 1));
      apply(both_v, 200 + i);
    end
    apply(idle_v, 300);
    apply(idle_v, 301);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
